// File: rtl/bp_be_pipe_int_clmul.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr, full and word forms).
// Consumes bits_per_cycle_p multiplier bits per BUSY cycle; the result is held until yumi.

module bp_be_clmul_lane #(
  parameter int width_p = 64,
  parameter int j_p     = 0
) (
  input  logic                   bit_i,
  input  logic [2*width_p-1:0]   rs1_i,
  output logic [2*width_p-1:0]   pp_o
);
  assign pp_o = bit_i ? (rs1_i << j_p) : '0;
endmodule

module bp_be_pipe_int_clmul #(
  parameter int width_p          = 64,
  parameter int bits_per_cycle_p = 4,
  parameter int tag_width_p      = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  input  logic                   v_i,
  output logic                   ready_and_o,
  input  logic [1:0]             op_i,
  input  logic                   opw_i,
  input  logic [width_p-1:0]     rs1_i,
  input  logic [width_p-1:0]     rs2_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i
);
  localparam int half_lp = width_p/2;
  localparam int acc_lp  = 2*width_p;
  localparam int n_full  = width_p/bits_per_cycle_p;
  localparam int n_word  = half_lp/bits_per_cycle_p;
  localparam int cnt_w   = (n_full > 1) ? $clog2(n_full) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic [1:0]             op;
    logic                   opw;
    logic [tag_width_p-1:0] tag;
  } req_s;

  state_e state_r, state_n;
  req_s   req_r;
  logic [acc_lp-1:0]  rs1_sh, acc_r, acc_nxt;
  logic [width_p-1:0] rs2_sh, mask;
  logic [cnt_w-1:0]   cnt_r, cnt_last;
  logic               accept, last;

  logic [bits_per_cycle_p-1:0][acc_lp-1:0] pp;
  logic [bits_per_cycle_p:0][acc_lp-1:0]   xr;

  // rs1 is pre-shifted each cycle, so lane j only ever needs a fixed shift by j
  assign xr[0] = acc_r;
  for (genvar j = 0; j < bits_per_cycle_p; j++) begin : g_lane
    bp_be_clmul_lane #(.width_p(width_p), .j_p(j)) lane (
      .bit_i (rs2_sh[j]),
      .rs1_i (rs1_sh),
      .pp_o  (pp[j])
    );
    assign xr[j+1] = xr[j] ^ pp[j];
  end
  assign acc_nxt = xr[bits_per_cycle_p];

  assign accept   = (state_r == IDLE) & v_i & ~flush_i;
  assign cnt_last = req_r.opw ? cnt_w'(n_word-1) : cnt_w'(n_full-1);
  assign last     = (state_r == BUSY) & (cnt_r == cnt_last);
  assign mask     = opw_i ? {{half_lp{1'b0}}, {half_lp{1'b1}}} : '1;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;

  always_comb begin
    state_n = state_r;
    if (flush_i) state_n = IDLE;
    else case (state_r)
      IDLE:    if (v_i)    state_n = BUSY;
      BUSY:    if (last)   state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result select on the final accumulator value
  logic [width_p-1:0] f_sel, res;
  logic [half_lp-1:0] w_sel;
  always_comb begin
    case (req_r.op)
      2'b01:   begin f_sel = acc_nxt[acc_lp-1:width_p];  w_sel = acc_nxt[width_p-1:half_lp];   end
      2'b10:   begin f_sel = acc_nxt[acc_lp-2:width_p-1]; w_sel = acc_nxt[width_p-2:half_lp-1]; end
      default: begin f_sel = acc_nxt[width_p-1:0];       w_sel = acc_nxt[half_lp-1:0];         end
    endcase
    res = req_r.opw ? {{half_lp{w_sel[half_lp-1]}}, w_sel} : f_sel;
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      req_r  <= '0;
      rs1_sh <= '0;
      rs2_sh <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      data_o <= '0;
      tag_o  <= '0;
    end else if (accept) begin
      req_r  <= '{op: op_i, opw: opw_i, tag: tag_i};
      rs1_sh <= {{width_p{1'b0}}, rs1_i & mask};
      rs2_sh <= rs2_i & mask;
      acc_r  <= '0;
      cnt_r  <= '0;
    end else if ((state_r == BUSY) && !flush_i) begin
      rs1_sh <= rs1_sh << bits_per_cycle_p;
      rs2_sh <= rs2_sh >> bits_per_cycle_p;
      acc_r  <= acc_nxt;
      cnt_r  <= cnt_r + 1'b1;
      if (last) begin
        data_o <= res;
        tag_o  <= req_r.tag;
      end
    end

  assign v_o         = (state_r == DONE);
  assign ready_and_o = (state_r == IDLE);

endmodule

// File: tb/tb_bp_be_pipe_int_clmul.sv
// Scoreboard bench for bp_be_pipe_int_clmul: directed vectors, monitor pops on each new result.

module tb_bp_be_pipe_int_clmul;
  logic        clk = 0, reset_n = 0, flush = 0, v_i = 0, ready, opw = 0, v_o, yumi = 0;
  logic [1:0]  op = 0;
  logic [63:0] rs1 = 0, rs2 = 0, data;
  logic [4:0]  tag_i = 0, tag_o;

  bp_be_pipe_int_clmul #(.width_p(64), .bits_per_cycle_p(4), .tag_width_p(5)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .v_i(v_i), .ready_and_o(ready),
    .op_i(op), .opw_i(opw), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag_i),
    .v_o(v_o), .data_o(data), .tag_o(tag_o), .yumi_i(yumi)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] d; logic [4:0] t; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare each new result against the head of the scoreboard
  logic prev_v = 0;
  always @(negedge clk) begin
    if (v_o && !prev_v) begin
      if (q.size() == 0) check("unexpected_result_tag", {59'd0, tag_o}, 64'h3f);
      else begin
        exp_t e;
        e = q.pop_front();
        check("sb_data", data, e.d);
        check("sb_tag", {59'd0, tag_o}, {59'd0, e.t});
      end
    end
    prev_v = v_o;
  end

  task automatic send(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] t);
    int n = 0;
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    op = o; opw = w; rs1 = a; rs2 = b; tag_i = t; v_i = 1;
    @(posedge clk); #1;
    v_i = 0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat = 0;
    logic rdy_seen = 0;
    while (!v_o && lat < 100) begin
      if (ready) rdy_seen = 1;
      @(posedge clk); #1; lat++;
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_ready_busy"}, rdy_seen, 0);
  endtask

  task automatic take(input string nm);
    yumi = 1;
    @(posedge clk); #1;
    yumi = 0;
    check({nm, "_vo_after_yumi"}, v_o, 0);
    check({nm, "_ready_after_yumi"}, ready, 1);
  endtask

  task automatic run(input string nm, input logic [1:0] o, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp, input int lat);
    q.push_back('{d: exp, t: t});
    send(o, w, a, b, t);
    wait_done(nm, lat);
    take(nm);
  endtask

  initial begin
    logic [63:0] hd;
    logic [4:0]  ht;
    #12;
    check("reset_vo", v_o, 0);
    check("reset_ready", ready, 1);
    check("reset_data", data, 0);
    check("reset_tag", {59'd0, tag_o}, 0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    run("clmul_3x3", 2'b00, 0, 64'd3, 64'd3, 5'd1, 64'h5, 16);
    run("clmulh", 2'b01, 0, 64'h8000_0000_0000_0000, 64'd2, 5'd2, 64'h1, 16);
    run("clmul_hi_only", 2'b00, 0, 64'h8000_0000_0000_0000, 64'd2, 5'd3, 64'h0, 16);
    run("clmulr", 2'b10, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 64'h8000_0000_0000_0000, 16);
    run("word", 2'b00, 1, 64'hDEAD_BEEF_8000_0000, 64'hFFFF_FFFF_0000_0001, 5'd5, 64'hFFFF_FFFF_8000_0000, 8);

    // yumi with no result is ignored
    yumi = 1; @(posedge clk); #1; yumi = 0;
    check("stray_yumi_ready", ready, 1);
    check("stray_yumi_vo", v_o, 0);

    // backpressure: hold result five cycles, then yumi with a competing v_i
    q.push_back('{d: 64'h5, t: 5'd6});
    send(2'b00, 0, 64'd3, 64'd3, 5'd6);
    wait_done("bp", 16);
    hd = data; ht = tag_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_vo", v_o, 1);
      check("bp_hold_data", data, hd);
      check("bp_hold_tag", {59'd0, tag_o}, {59'd0, ht});
      check("bp_hold_ready", ready, 0);
    end
    yumi = 1; v_i = 1; tag_i = 5'd9;
    @(posedge clk); #1;
    yumi = 0; v_i = 0;
    check("bp_yumi_ready", ready, 1);
    check("bp_yumi_vo", v_o, 0);
    @(posedge clk); #1;
    check("bp_no_accept_on_yumi", ready, 1);

    // flush on BUSY cycle 5
    send(2'b00, 0, 64'd7, 64'd7, 5'd10);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1; @(posedge clk); #1; flush = 0;
    check("flush_ready", ready, 1);
    check("flush_vo", v_o, 0);
    begin
      logic seen = 0;
      repeat (20) begin @(posedge clk); #1; if (v_o) seen = 1; end
      check("flush_no_result", seen, 0);
    end
    run("post_flush", 2'b00, 0, 64'hF, 64'h3, 5'd11, 64'h11, 16);

    // flush with v_i in IDLE
    flush = 1; v_i = 1; @(posedge clk); #1; flush = 0; v_i = 0;
    check("flush_idle_no_accept", ready, 1);

    // asynchronous reset mid-BUSY
    send(2'b00, 0, 64'd3, 64'd3, 5'd12);
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("async_rst_vo", v_o, 0);
    check("async_rst_ready", ready, 1);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    check("rst_release_ready", ready, 1);
    check("rst_release_vo", v_o, 0);
    check("rst_release_data", data, 0);
    begin
      logic seen = 0;
      repeat (20) begin @(posedge clk); #1; if (v_o) seen = 1; end
      check("rst_no_result", seen, 0);
    end

    run("reserved_op", 2'b11, 0, 64'd3, 64'd3, 5'd13, 64'h5, 16);

    repeat (3) @(posedge clk);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/bp_be_pipe_int_clmul.md
Name: bp_be_pipe_int_clmul

Overview:
- Iterative, parametrised carry-less multiply unit for the BE calculator (Zbc ops clmul/clmulh/clmulr, 64-bit and W-word forms).
- Sits beside the single-cycle integer pipe as a long-latency integer pipe, with a ready/valid input, a held output that needs a yumi, and a flush.
- Processes bits_per_cycle_p multiplier bits per cycle, so area against latency is set at elaboration.

Parameters:
width_p, 64, full operand/result width; must be even
bits_per_cycle_p, 4, multiplier bits consumed per BUSY cycle; power of 2, divides width_p/2
tag_width_p, 5, width of the pass-through destination tag (rd address)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_n_i  input  1  asynchronous active-low reset
flush_i  input  1  kill any in-flight or held operation
v_i  input  1  request valid
ready_and_o  output  1  unit can accept a request this cycle
op_i  input  2  00 clmul, 01 clmulh, 10 clmulr, 11 reserved (executes as clmul)
opw_i  input  1  word form: operate on low width_p/2 bits, sign-extend result
rs1_i  input  width_p  multiplicand
rs2_i  input  width_p  multiplier
tag_i  input  tag_width_p  destination tag, returned unchanged
v_o  output  1  result valid, held until yumi_i
data_o  output  width_p  result
tag_o  output  tag_width_p  tag of the result
yumi_i  input  1  consumer takes the result; legal only when v_o=1

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, v_o=0, data_o=0, tag_o=0, accumulator/counter=0. Reset mid-operation aborts it; no result is produced.
- Effective width E = opw_i ? width_p/2 : width_p. Iteration count N = E/bits_per_cycle_p (default: 16 full, 8 word).
- States:
  - IDLE: ready_and_o=1.
    - Accept when v_i & ready_and_o & !flush_i.
    - On accept, latch rs1 and rs2 masked to their low E bits, op, opw and tag.
    - On accept, clear the 2*width_p-bit accumulator and the counter, then go to BUSY.
  - BUSY: ready_and_o=0.
    - Each cycle, for j in 0..bits_per_cycle_p-1 with bit index k = counter*bits_per_cycle_p + j: if rs2[k], acc ^= rs1 << k.
    - The counter then increments. After the N-th BUSY cycle, go to DONE.
  - DONE: v_o=1, ready_and_o=0.
    - Result is registered on entry to DONE and stable for the whole state.
    - yumi_i -> IDLE next cycle. No same-cycle accept in DONE (no bypass).
- Latency: request accepted at edge t -> v_o=1 first in the cycle after edge t+N (N BUSY cycles). Throughput is one op per N+2 cycles minimum.
- Result selection, with P = acc[2E-1:0]:
  - clmul = P[E-1:0]
  - clmulh = P[2E-1:E]
  - clmulr = P[2E-2:E-1]
  - opw_i=1: the E-bit result is sign-extended from bit E-1 to width_p.
  - opw_i=0: the result is used as-is.
- Upper operand bits are ignored when opw_i=1.
- flush_i:
  - In any state, forces IDLE next cycle; v_o=0 from the next cycle; the held result is discarded.
  - Flush has priority over accept and yumi.
  - A v_i in the same cycle as flush is not accepted.
- yumi_i when v_o=0 is ignored (must not change state). v_i while ready_and_o=0 is ignored; the requester must hold.
- data_o/tag_o hold their last value outside DONE (not required to be zero).

Test Plan:
- Full clmul: rs1=3, rs2=3, op=00, opw=0 -> data_o=0x5. v_o rises exactly 16 cycles after the accept edge. ready_and_o=0 throughout.
- clmulh/clmulr:
  - rs1=0x8000_0000_0000_0000, rs2=2, op=01 -> 0x1. Same operands, op=00 -> 0x0.
  - rs1=rs2=0x8000_0000_0000_0000, op=10 -> 0x8000_0000_0000_0000.
- Word form: opw=1, rs1=0xDEAD_BEEF_8000_0000, rs2=0xFFFF_FFFF_0000_0001, op=00 -> 0xFFFF_FFFF_8000_0000. Latency is 8 BUSY cycles.
- Backpressure: complete an op and hold yumi_i=0 for 5 cycles -> v_o, data_o and tag_o stable, ready_and_o=0. yumi on cycle 6 -> IDLE and ready_and_o=1 the next cycle. A v_i on the yumi cycle is not accepted.
- Flush: flush_i on BUSY cycle 5 -> no v_o ever for that tag. The next request completes correctly (rs1=0xF, rs2=0x3 -> 0x11). flush_i with v_i in IDLE -> not accepted.
- Reset: drop reset_n_i mid-BUSY asynchronously -> v_o=0 and ready_and_o=1 immediately after release. Reserved op=11 with rs1=3, rs2=3 -> 0x5.
